// File: rtl/stream_pkg.sv
// Shared helpers for the narrow-to-wide stream converter.
// No logic of its own: constants and a lane-offset helper only.
// Not applicable (no handshake in a package).
package stream_pkg;

  // Narrow beats per wide word when the instantiator does not override it.
  localparam int DefaultRatio = 4;

  // Bit offset of a lane inside a packed wide word.
  function automatic int lane_offset(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/stream_upsizer.sv
// Packs Ratio narrow valid/ready beats into one registered wide word with lane strobes.
// Latency: the completing beat's word is on valid_o the cycle after it is accepted.
// Backpressure: ready_o = !flush_i && (!valid_o || ready_i); a stalled output pauses accumulation.
module stream_upsizer
  import stream_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int Ratio     = DefaultRatio
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [DataWidth-1:0]       data_i,
  input  logic                       last_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [DataWidth*Ratio-1:0] data_o,
  output logic [Ratio-1:0]           strb_o,
  output logic                       last_o
);

  localparam int CntWidth  = $clog2(Ratio);
  localparam int WordWidth = DataWidth * Ratio;
  localparam logic [CntWidth-1:0] LastLane = CntWidth'(Ratio - 1);

  // Lane counter and accumulation buffer.
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [WordWidth-1:0] acc_data_q, acc_data_d;
  logic [Ratio-1:0]     acc_strb_q, acc_strb_d;

  // Output register.
  logic                 out_valid_q, out_valid_d;
  logic [WordWidth-1:0] data_q, data_d;
  logic [Ratio-1:0]     strb_q, strb_d;
  logic                 last_q, last_d;

  // Accumulator with the incoming beat merged into lane cnt_q.
  logic [WordWidth-1:0] merged_data;
  logic [Ratio-1:0]     merged_strb;

  logic accept;
  logic pop;
  logic complete;

  // The ready path is combinational through ready_i; the upstream spill register absorbs it.
  assign ready_o  = !flush_i && (!out_valid_q || ready_i);
  assign accept   = valid_i && ready_o;
  assign pop      = out_valid_q && ready_i;
  assign complete = accept && ((cnt_q == LastLane) || last_i);

  assign valid_o = out_valid_q;
  assign data_o  = data_q;
  assign strb_o  = strb_q;
  assign last_o  = last_q;

  // Merge the incoming beat into the lane selected by the counter.
  always_comb begin
    merged_data = acc_data_q;
    merged_strb = acc_strb_q;
    for (int k = 0; k < Ratio; k++) begin
      if (cnt_q == CntWidth'(k)) begin
        merged_data[lane_offset(k, DataWidth) +: DataWidth] = data_i;
        merged_strb[k] = 1'b1;
      end
    end
  end

  // Next-state for counter, accumulator and output register; flush overrides everything.
  always_comb begin
    cnt_d       = cnt_q;
    acc_data_d  = acc_data_q;
    acc_strb_d  = acc_strb_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    strb_d      = strb_q;
    last_d      = last_q;

    if (flush_i) begin
      // ready_o is low here, so no beat can be accepted this cycle.
      cnt_d       = '0;
      acc_data_d  = '0;
      acc_strb_d  = '0;
      out_valid_d = 1'b0;
    end else begin
      if (pop) begin
        out_valid_d = 1'b0;
      end
      if (complete) begin
        // A same-cycle pop frees the register, so the new word loads without a bubble.
        data_d      = merged_data;
        strb_d      = merged_strb;
        last_d      = last_i;
        out_valid_d = 1'b1;
        cnt_d       = '0;
        acc_data_d  = '0;
        acc_strb_d  = '0;
      end else if (accept) begin
        // Explicit wrap is handled by completion at LastLane, so this never overflows.
        cnt_d      = cnt_q + CntWidth'(1);
        acc_data_d = merged_data;
        acc_strb_d = merged_strb;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      acc_data_q  <= '0;
      acc_strb_q  <= '0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      strb_q      <= '0;
      last_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_data_q  <= acc_data_d;
      acc_strb_q  <= acc_strb_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      strb_q      <= strb_d;
      last_q      <= last_d;
    end
  end

endmodule

// File: tb/tb_stream_upsizer.sv
// Directed bench for stream_upsizer with DataWidth=8, Ratio=4.
// Outputs sampled 1 time unit after the rising edge; inputs changed at the same point.
// Downstream ready is driven directly by the scenarios.
module tb_stream_upsizer;

  logic        clk_i;
  logic        rst_i;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [7:0]  data_i;
  logic        last_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] data_o;
  logic [3:0]  strb_o;
  logic        last_o;

  int chk_cnt;
  int pass_cnt;

  stream_upsizer #(
    .DataWidth(8),
    .Ratio(4)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .flush_i(flush_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_i (data_i),
    .last_i (last_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .data_o (data_o),
    .strb_o (strb_o),
    .last_o (last_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; data_i = '0; last_i = 1'b0; ready_i = 1'b1;
    tick; tick;
    rst_i = 1'b0;
    #1;
    chk_cnt++; if (valid_o !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid_o); else pass_cnt++;
    chk_cnt++; if (data_o !== 32'h0) $display("FAIL reset_data got=%h exp=00000000", data_o); else pass_cnt++;
    chk_cnt++; if (strb_o !== 4'h0) $display("FAIL reset_strb got=%b exp=0000", strb_o); else pass_cnt++;
    chk_cnt++; if (last_o !== 1'b0) $display("FAIL reset_last got=%b exp=0", last_o); else pass_cnt++;
    chk_cnt++; if (ready_o !== 1'b1) $display("FAIL reset_ready got=%b exp=1", ready_o); else pass_cnt++;
  endtask

  task automatic test_full_word;
    logic [7:0] beats [4];
    beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33; beats[3] = 8'h44;
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1; data_i = beats[i]; last_i = 1'b0;
      #1;
      chk_cnt++; if (ready_o !== 1'b1) $display("FAIL full_ready beat=%0d got=%b exp=1", i, ready_o); else pass_cnt++;
      chk_cnt++; if (valid_o !== 1'b0) $display("FAIL full_early_valid beat=%0d got=%b exp=0", i, valid_o); else pass_cnt++;
      tick;
    end
    valid_i = 1'b0;
    chk_cnt++; if (valid_o !== 1'b1) $display("FAIL full_valid got=%b exp=1", valid_o); else pass_cnt++;
    chk_cnt++; if (data_o !== 32'h44332211) $display("FAIL full_data got=%h exp=44332211", data_o); else pass_cnt++;
    chk_cnt++; if (strb_o !== 4'b1111) $display("FAIL full_strb got=%b exp=1111", strb_o); else pass_cnt++;
    chk_cnt++; if (last_o !== 1'b0) $display("FAIL full_last got=%b exp=0", last_o); else pass_cnt++;
    tick;
    chk_cnt++; if (valid_o !== 1'b0) $display("FAIL full_one_cycle got=%b exp=0", valid_o); else pass_cnt++;
  endtask

  task automatic test_early_last;
    ready_i = 1'b1;
    valid_i = 1'b1; data_i = 8'hAA; last_i = 1'b0;
    tick;
    data_i = 8'hBB; last_i = 1'b1;
    tick;
    valid_i = 1'b0; last_i = 1'b0;
    chk_cnt++; if (valid_o !== 1'b1) $display("FAIL early_valid got=%b exp=1", valid_o); else pass_cnt++;
    chk_cnt++; if (data_o !== 32'h0000BBAA) $display("FAIL early_data got=%h exp=0000bbaa", data_o); else pass_cnt++;
    chk_cnt++; if (strb_o !== 4'b0011) $display("FAIL early_strb got=%b exp=0011", strb_o); else pass_cnt++;
    chk_cnt++; if (last_o !== 1'b1) $display("FAIL early_last got=%b exp=1", last_o); else pass_cnt++;
    tick;
    // Next word must start at lane 0; a last on lane 0 gives a one-lane word.
    valid_i = 1'b1; data_i = 8'hCC; last_i = 1'b1;
    tick;
    valid_i = 1'b0; last_i = 1'b0;
    chk_cnt++; if (data_o !== 32'h000000CC) $display("FAIL lane0_data got=%h exp=000000cc", data_o); else pass_cnt++;
    chk_cnt++; if (strb_o !== 4'b0001) $display("FAIL lane0_strb got=%b exp=0001", strb_o); else pass_cnt++;
    chk_cnt++; if (last_o !== 1'b1) $display("FAIL lane0_last got=%b exp=1", last_o); else pass_cnt++;
    tick;
  endtask

  task automatic test_backpressure;
    ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      valid_i = 1'b1; data_i = 8'(i); last_i = 1'b0;
      tick;
    end
    // Word 2's first beat is presented and held through the stall.
    data_i = 8'h05;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk_cnt++; if (ready_o !== 1'b0) $display("FAIL bp_ready cyc=%0d got=%b exp=0", c, ready_o); else pass_cnt++;
      chk_cnt++; if (valid_o !== 1'b1) $display("FAIL bp_valid cyc=%0d got=%b exp=1", c, valid_o); else pass_cnt++;
      chk_cnt++; if (data_o !== 32'h04030201) $display("FAIL bp_data cyc=%0d got=%h exp=04030201", c, data_o); else pass_cnt++;
      tick;
    end
    ready_i = 1'b1;
    #1;
    chk_cnt++; if (ready_o !== 1'b1) $display("FAIL bp_release_ready got=%b exp=1", ready_o); else pass_cnt++;
    chk_cnt++; if (data_o !== 32'h04030201) $display("FAIL bp_word1 got=%h exp=04030201", data_o); else pass_cnt++;
    tick;
    chk_cnt++; if (valid_o !== 1'b0) $display("FAIL bp_popped got=%b exp=0", valid_o); else pass_cnt++;
    for (int i = 6; i <= 8; i++) begin
      data_i = 8'(i);
      tick;
    end
    valid_i = 1'b0;
    chk_cnt++; if (valid_o !== 1'b1) $display("FAIL bp_word2_valid got=%b exp=1", valid_o); else pass_cnt++;
    chk_cnt++; if (data_o !== 32'h08070605) $display("FAIL bp_word2 got=%h exp=08070605", data_o); else pass_cnt++;
    tick;
  endtask

  task automatic test_streaming;
    logic [31:0] exp_words [3];
    int ready_drops;
    exp_words[0] = 32'h04030201; exp_words[1] = 32'h08070605; exp_words[2] = 32'h0C0B0A09;
    ready_drops = 0;
    ready_i = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      valid_i = 1'b1; data_i = 8'(i); last_i = 1'b0;
      #1;
      if (ready_o !== 1'b1) ready_drops++;
      tick;
      if ((i % 4) == 0) begin
        chk_cnt++; if (valid_o !== 1'b1) $display("FAIL stream_valid beat=%0d got=%b exp=1", i, valid_o); else pass_cnt++;
        chk_cnt++; if (data_o !== exp_words[i/4-1]) $display("FAIL stream_data beat=%0d got=%h exp=%h", i, data_o, exp_words[i/4-1]); else pass_cnt++;
      end else begin
        chk_cnt++; if (valid_o !== 1'b0) $display("FAIL stream_idle beat=%0d got=%b exp=0", i, valid_o); else pass_cnt++;
      end
    end
    valid_i = 1'b0;
    chk_cnt++; if (ready_drops !== 0) $display("FAIL stream_ready_drops got=%0d exp=0", ready_drops); else pass_cnt++;
    tick;
  endtask

  task automatic test_flush;
    ready_i = 1'b1;
    valid_i = 1'b1; data_i = 8'h99; last_i = 1'b0;
    tick;
    data_i = 8'h9A;
    tick;
    // Beat offered during flush must not be taken.
    data_i = 8'hEE; flush_i = 1'b1;
    #1;
    chk_cnt++; if (ready_o !== 1'b0) $display("FAIL flush_ready got=%b exp=0", ready_o); else pass_cnt++;
    tick;
    flush_i = 1'b0;
    chk_cnt++; if (valid_o !== 1'b0) $display("FAIL flush_no_output got=%b exp=0", valid_o); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      data_i = 8'h55 + 8'(i);
      tick;
    end
    valid_i = 1'b0;
    chk_cnt++; if (valid_o !== 1'b1) $display("FAIL flush_next_valid got=%b exp=1", valid_o); else pass_cnt++;
    chk_cnt++; if (data_o !== 32'h58575655) $display("FAIL flush_next_data got=%h exp=58575655", data_o); else pass_cnt++;
    chk_cnt++; if (strb_o !== 4'b1111) $display("FAIL flush_next_strb got=%b exp=1111", strb_o); else pass_cnt++;
    tick;
  endtask

  task automatic test_reset_mid_stall;
    ready_i = 1'b0;
    valid_i = 1'b1; data_i = 8'h61; last_i = 1'b0;
    tick;
    data_i = 8'h62; last_i = 1'b1;
    tick;
    valid_i = 1'b0; last_i = 1'b0;
    tick;
    chk_cnt++; if (data_o !== 32'h00006261) $display("FAIL stall_data got=%h exp=00006261", data_o); else pass_cnt++;
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    chk_cnt++; if (valid_o !== 1'b0) $display("FAIL rst_stall_valid got=%b exp=0", valid_o); else pass_cnt++;
    chk_cnt++; if (data_o !== 32'h0) $display("FAIL rst_stall_data got=%h exp=00000000", data_o); else pass_cnt++;
    chk_cnt++; if (strb_o !== 4'h0) $display("FAIL rst_stall_strb got=%b exp=0000", strb_o); else pass_cnt++;
    chk_cnt++; if (last_o !== 1'b0) $display("FAIL rst_stall_last got=%b exp=0", last_o); else pass_cnt++;
    ready_i = 1'b1;
    valid_i = 1'b1; data_i = 8'h71; last_i = 1'b1;
    tick;
    valid_i = 1'b0; last_i = 1'b0;
    chk_cnt++; if (data_o !== 32'h00000071) $display("FAIL rst_restart_data got=%h exp=00000071", data_o); else pass_cnt++;
    chk_cnt++; if (strb_o !== 4'b0001) $display("FAIL rst_restart_strb got=%b exp=0001", strb_o); else pass_cnt++;
    tick;
    // Reset mid-word discards the partial lanes.
    valid_i = 1'b1; data_i = 8'h81;
    tick;
    valid_i = 1'b0; rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_i = 8'h91 + 8'(i);
      tick;
    end
    valid_i = 1'b0;
    chk_cnt++; if (data_o !== 32'h94939291) $display("FAIL rst_midword_data got=%h exp=94939291", data_o); else pass_cnt++;
    tick;
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    test_reset();
    test_full_word();
    test_early_last();
    test_backpressure();
    test_streaming();
    test_flush();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
